vga_timing_gen: RTL and testbench

Raster timing generator for the 640x480@60 VGA path. It sits directly upstream of the text and sprite renderers. It owns the horizontal and vertical counters and produces the beam position, the sync pulses and the display-enable. It also produces per-line and per-frame strobes for animation state, plus a frame counter. A configurable delay line re-times sync and display-enable to match the renderer's pipeline latency.

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/sync_delay_line.sv | 37 +++
 rtl/vga_timing_gen.sv | 134 +++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the timing generator and the renderers.
package vga_timing_pkg;

  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_BOTTOM  = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_TOP     = 33;

  localparam int unsigned VGA_H_TOTAL =
      VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL =
      VGA_V_DISPLAY + VGA_V_BOTTOM + VGA_V_SYNC + VGA_V_TOP;

  localparam logic SYNC_ACTIVE_LOW = 1'b0;

  localparam int unsigned POS_W = 10;

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register with async active-low reset to a per-bit value.
module sync_delay_line #(
  parameter int unsigned      Width    = 3,
  parameter int unsigned      Depth    = 0,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, ena};
    assign dout = din;
  end else begin : g_pipe
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(Depth); i++) begin
          stage_q[i] <= ResetVal;
        end
      end else if (ena) begin
        stage_q[0] <= din;
        for (int i = 1; i < int'(Depth); i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign dout = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, registered sync/enable/strobe decode and frame counter for the VGA path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT     = VGA_H_FRONT,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BACK      = VGA_H_BACK,
  parameter int unsigned V_DISPLAY   = VGA_V_DISPLAY,
  parameter int unsigned V_BOTTOM    = VGA_V_BOTTOM,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_TOP       = VGA_V_TOP,
  parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_LOW,
  parameter int unsigned PIPE_DLY    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        hsync,
  output logic        vsync,
  output logic        display_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        frame_tick,
  output logic [15:0] frame_count,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        display_on_d
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..7");
  end

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_BOTTOM);
  localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [POS_W-1:0] hpos_q, vpos_q, hpos_d, vpos_d;
  logic             hsync_q, vsync_q, display_on_q;
  logic             hsync_n, vsync_n, display_on_n;
  logic             line_start_q, frame_start_q, frame_tick_q;
  logic             line_start_n, frame_start_n, frame_tick_n;
  logic [15:0]      frame_count_q;
  // Distinguishes the reset-parked position from a genuine end of frame.
  logic             started_q;

  always_comb begin
    hpos_d = hpos_q + POS_W'(1);
    vpos_d = vpos_q;
    if (hpos_q == H_LAST) begin
      hpos_d = '0;
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + POS_W'(1);
    end

    // Decode from the next position so the registered flags line up with hpos/vpos.
    hsync_n       = (hpos_d >= HS_FIRST && hpos_d <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_n       = (vpos_d >= VS_FIRST && vpos_d <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    display_on_n  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    line_start_n  = (hpos_d == '0);
    frame_start_n = line_start_n && (vpos_d == '0);
    frame_tick_n  = line_start_n && (vpos_d == V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= '0;
      started_q     <= 1'b0;
    end else if (ena) begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_n;
      vsync_q       <= vsync_n;
      display_on_q  <= display_on_n;
      line_start_q  <= line_start_n;
      frame_start_q <= frame_start_n;
      frame_tick_q  <= frame_tick_n;
      started_q     <= 1'b1;
      if (frame_start_n && started_q) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;

  localparam logic [2:0] DLY_RESET = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  logic [2:0] dly_out;

  sync_delay_line #(
    .Width    (3),
    .Depth    (PIPE_DLY),
    .ResetVal (DLY_RESET)
  ) u_sync_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .din   ({hsync_q, vsync_q, display_on_q}),
    .dout  (dly_out)
  );

  assign {hsync_d, vsync_d, display_on_d} = dly_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Random-enable bench: full-size instance (PIPE_DLY=3) and a tiny-raster instance (PIPE_DLY=0)
// both checked every cycle against a position-from-edge-count reference model.
module tb_vga_timing_gen;

  typedef struct {
    int hd, hf, hs, hb, vd, vb, vs, vt;
  } geom_t;

  typedef struct {
    int hpos, vpos;
    bit hs, vs, de, ls, fs, ft;
    int fc;
  } exp_t;

  logic clk, rst_n, ena;

  logic [9:0]  a_hpos, a_vpos, b_hpos, b_vpos;
  logic        a_hs, a_vs, a_de, a_ls, a_fs, a_ft, a_hsd, a_vsd, a_ded;
  logic        b_hs, b_vs, b_de, b_ls, b_fs, b_ft, b_hsd, b_vsd, b_ded;
  logic [15:0] a_fc, b_fc;

  int    n_checks, n_errors;
  int    n_edges;
  geom_t ga, gb;

  vga_timing_gen #(
    .PIPE_DLY (3)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .hpos         (a_hpos),
    .vpos         (a_vpos),
    .hsync        (a_hs),
    .vsync        (a_vs),
    .display_on   (a_de),
    .line_start   (a_ls),
    .frame_start  (a_fs),
    .frame_tick   (a_ft),
    .frame_count  (a_fc),
    .hsync_d      (a_hsd),
    .vsync_d      (a_vsd),
    .display_on_d (a_ded)
  );

  vga_timing_gen #(
    .H_DISPLAY (16),
    .H_FRONT   (2),
    .H_SYNC    (4),
    .H_BACK    (3),
    .V_DISPLAY (10),
    .V_BOTTOM  (2),
    .V_SYNC    (2),
    .V_TOP     (3),
    .PIPE_DLY  (0)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .hpos         (b_hpos),
    .vpos         (b_vpos),
    .hsync        (b_hs),
    .vsync        (b_vs),
    .display_on   (b_de),
    .line_start   (b_ls),
    .frame_start  (b_fs),
    .frame_tick   (b_ft),
    .frame_count  (b_fc),
    .hsync_d      (b_hsd),
    .vsync_d      (b_vsd),
    .display_on_d (b_ded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n enabled edges since reset (n=0 is the reset state).
  function automatic exp_t model(input geom_t g, input int n);
    exp_t e;
    int   ht, vt, frame, p, hs0, vs0;
    ht = g.hd + g.hf + g.hs + g.hb;
    vt = g.vd + g.vb + g.vs + g.vt;
    if (n <= 0) begin
      e = '{hpos: ht - 1, vpos: vt - 1, hs: 1, vs: 1, de: 0, ls: 0, fs: 0, ft: 0, fc: 0};
      return e;
    end
    frame  = ht * vt;
    p      = (n - 1) % frame;
    e.hpos = p % ht;
    e.vpos = p / ht;
    hs0    = g.hd + g.hf;
    vs0    = g.vd + g.vb;
    e.hs   = !(e.hpos >= hs0 && e.hpos < hs0 + g.hs);
    e.vs   = !(e.vpos >= vs0 && e.vpos < vs0 + g.vs);
    e.de   = (e.hpos < g.hd) && (e.vpos < g.vd);
    e.ls   = (e.hpos == 0);
    e.fs   = e.ls && (e.vpos == 0);
    e.ft   = e.ls && (e.vpos == g.vd);
    e.fc   = ((n - 1) / frame) % 65536;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: observed %0d expected %0d", tag, n_edges, obs, exp);
    end
  endtask

  task automatic check_dut(input string pfx, input geom_t g, input int dly,
                           input logic [9:0] hp, input logic [9:0] vp,
                           input logic hs, input logic vs, input logic de,
                           input logic ls, input logic fs, input logic ft,
                           input logic [15:0] fc,
                           input logic hsd, input logic vsd, input logic ded);
    exp_t e, ed;
    e  = model(g, n_edges);
    ed = model(g, n_edges - dly);
    check_val({pfx, ".hpos"},         32'(hp),  32'(e.hpos));
    check_val({pfx, ".vpos"},         32'(vp),  32'(e.vpos));
    check_val({pfx, ".hsync"},        32'(hs),  32'(e.hs));
    check_val({pfx, ".vsync"},        32'(vs),  32'(e.vs));
    check_val({pfx, ".display_on"},   32'(de),  32'(e.de));
    check_val({pfx, ".line_start"},   32'(ls),  32'(e.ls));
    check_val({pfx, ".frame_start"},  32'(fs),  32'(e.fs));
    check_val({pfx, ".frame_tick"},   32'(ft),  32'(e.ft));
    check_val({pfx, ".frame_count"},  32'(fc),  32'(e.fc));
    check_val({pfx, ".hsync_d"},      32'(hsd), 32'(ed.hs));
    check_val({pfx, ".vsync_d"},      32'(vsd), 32'(ed.vs));
    check_val({pfx, ".display_on_d"}, 32'(ded), 32'(ed.de));
  endtask

  task automatic check_all();
    check_dut("a", ga, 3, a_hpos, a_vpos, a_hs, a_vs, a_de, a_ls, a_fs, a_ft, a_fc,
              a_hsd, a_vsd, a_ded);
    check_dut("b", gb, 0, b_hpos, b_vpos, b_hs, b_vs, b_de, b_ls, b_fs, b_ft, b_fc,
              b_hsd, b_vsd, b_ded);
  endtask

  // Inputs change just after a falling edge; outputs are sampled on the falling edge.
  task automatic step(input logic e);
    ena = e;
    @(posedge clk);
    if (e) n_edges++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_edges  = 0;
    ga = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vb: 10, vs: 2, vt: 33};
    gb = '{hd: 16, hf: 2, hs: 4, hb: 3, vd: 10, vb: 2, vs: 2, vt: 3};
    ena   = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Two full lines of the large raster and several small frames.
    repeat (1700) step(1'b1);

    // Alternating enable: a line takes twice as many clocks.
    for (int i = 0; i < 2000; i++) step(i % 2 == 0);

    repeat (3000) step($urandom_range(0, 3) != 0);

    // Async reset between edges must take effect without a clock.
    #2 rst_n = 1'b0;
    n_edges = 0;
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    repeat (1500) step($urandom_range(0, 7) != 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
